mc_control: RTL and testbench
=============================

# mc_control

Multicycle MIPS main control unit: a Moore state machine that sequences fetch, decode, execute, memory and write-back for R-type, lw, sw, beq, j and jal. It replaces the single-cycle opcode decoder and sits between the instruction register's opcode field and the multicycle datapath's muxes and write enables. It stalls on a memory-ready handshake, traps illegal opcodes and carries retired-instruction and cycle counters for CPI measurement.

## Interface
Parameters:
- CNT_W, 32, width of the cycle and retired-instruction counters
- ALUOP_W, 2, width of the ALU-control selector

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  instr[31:26] from the instruction register
- mem_ready  in  1  memory has completed the current read/write this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite  out  1 each  datapath enables/selects
- MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC (jal link)
- RegDst  out  2  00 rt, 01 rd, 10 $31
- ALUSrcB  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target
- AluOP  out  ALUOP_W  00 add, 01 sub, 10 funct-decoded
- illegal  out  1  sticky illegal-opcode flag
- cycle_count, instr_count  out  CNT_W  performance counters

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, ALU_WB, BRANCH, JUMP, JAL, TRAP (+ ADDI_EXEC, ADDI_WB under macro).
- FETCH: MemRead, IorD=0, IRWrite, ALUSrcA=0, ALUSrcB=01, AluOP=00, PCSource=00; IRWrite and PCWrite asserted only in the cycle mem_ready=1; on that cycle -> DECODE, else stay.
- DECODE: ALUSrcA=0, ALUSrcB=11, AluOP=00 (branch target precompute). Opcode 000000->EXEC, 100011/101011->MEM_ADDR, 000100->BRANCH, 000010->JUMP, 000011->JAL, any other->TRAP.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, AluOP=00; lw->MEM_RD, sw->MEM_WR.
- MEM_RD: MemRead, IorD=1; hold until mem_ready, then -> MEM_WB. MEM_WB: RegWrite, RegDst=00, MemtoReg=01 -> FETCH.
- MEM_WR: MemWrite, IorD=1; hold until mem_ready, then -> FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, AluOP=10 -> ALU_WB: RegWrite, RegDst=01, MemtoReg=00 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, AluOP=01, PCWriteCond, PCSource=01 -> FETCH.
- JUMP: PCWrite, PCSource=10 -> FETCH. JAL: RegWrite, RegDst=10, MemtoReg=10, PCWrite, PCSource=10 -> FETCH (PC already holds PC+4).
- TRAP: all enables 0, illegal=1; absorbing until reset.
- Unlisted outputs in each state are 0 (no x values driven).
- instr_count +1 on every transition from a final state into FETCH; cycle_count +1 every cycle reset is low except in TRAP; both wrap modulo 2^CNT_W.

## Timing
- Outputs are combinational decode of the state register; state and counters update on rising clk.
- While reset=1: all enables and selects forced 0, illegal=0, counters cleared; first cycle after reset is FETCH.
- Latency with mem_ready held high: lw 5, sw 4, R-type 4, beq 3, j 3, jal 3 cycles; each cycle mem_ready=0 in FETCH/MEM_RD/MEM_WR adds one.
- mem_ready ignored in all other states.
- Reset mid-instruction aborts it; no write enable may assert in the reset cycle.

## Configuration
- MC_CONTROL_ADDI_EN: defined -> opcode 001000 goes DECODE->ADDI_EXEC (ALUSrcA=1, ALUSrcB=10, AluOP=00) -> ADDI_WB (RegWrite, RegDst=00, MemtoReg=00) -> FETCH, 4 cycles. Undefined -> 001000 is illegal and goes to TRAP.

## Structure
- Shared package mc_pkg: state enum, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_ADDI), AluOP, MemtoReg, RegDst, ALUSrcB, PCSource encodings.
- One sub-module: mc_perf_counters (cycle/retired counters, CNT_W parameter, inputs count_en and retire).

## Test plan
- Reset then lw with mem_ready=1 -> states FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB; RegWrite=1 with MemtoReg=01 in cycle 5; instr_count=1, cycle_count=5.
- sw with mem_ready low 3 cycles in MEM_WR -> MemWrite held 4 cycles, single write, total 7 cycles.
- beq then j then jal -> PCWriteCond in BRANCH only; jal cycle shows RegDst=10, MemtoReg=10, PCWrite=1; instr_count=3 after 9 cycles.
- Opcode 111111 -> TRAP after DECODE, illegal=1, no enables, counters frozen; reset clears illegal and returns to FETCH.
- Reset asserted in MEM_RD -> next cycle FETCH, RegWrite never asserted, counters 0.
- Opcode 001000 with and without MC_CONTROL_ADDI_EN -> 4-cycle write-back vs TRAP.

Source files
------------

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared state, opcode and datapath-select encodings for mc_control
// MC_CONTROL_ADDI_EN adds the ADDI_EXEC/ADDI_WB states.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEM_ADDR,
        MEM_RD,
        MEM_WB,
        MEM_WR,
        EXEC,
        ALU_WB,
        BRANCH,
        JUMP,
        JAL,
`ifdef MC_CONTROL_ADDI_EN
        ADDI_EXEC,
        ADDI_WB,
`endif
        TRAP
    } mc_state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] MTR_ALUOUT = 2'b00;
    localparam logic [1:0] MTR_MDR    = 2'b01;
    localparam logic [1:0] MTR_PC     = 2'b10;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

endpackage

// File: rtl/mc_perf_counters.sv
// rtl/mc_perf_counters.sv - free-running cycle and retired-instruction counters
module mc_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             count_en,
    input  logic             retire,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instr_q, instr_d;

    // Both counters wrap naturally at 2^CNT_W.
    always_comb begin
        cycle_d = cycle_q;
        instr_d = instr_q;
        if (count_en) cycle_d = cycle_q + CNT_W'(1);
        if (retire)   instr_d = instr_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            instr_q <= instr_d;
        end
    end

    assign cycle_count = cycle_q;
    assign instr_count = instr_q;

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multicycle MIPS main control FSM with memory stall, trap and CPI counters
// MC_CONTROL_ADDI_EN enables addi (opcode 001000); otherwise addi traps.
module mc_control
    import mc_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               ALUSrcA,
    output logic               RegWrite,
    output logic [1:0]         MemtoReg,
    output logic [1:0]         RegDst,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [ALUOP_W-1:0] AluOP,
    output logic               illegal,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [CNT_W-1:0]   instr_count
);

    mc_state_e  state_q, state_d;
    logic [1:0] aluop_c;
    logic       count_en;
    logic       retire;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Everything is gated by reset so no enable can fire in the reset cycle.
    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        MemtoReg    = MTR_ALUOUT;
        RegDst      = RD_RT;
        ALUSrcB     = SRCB_B;
        PCSource    = PCS_ALU;
        aluop_c     = ALUOP_ADD;
        illegal     = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        state_d = DECODE;
                    end
                end
                DECODE: begin
                    ALUSrcB = SRCB_IMM_SH2;
                    case (opcode)
                        OP_RTYPE:     state_d = EXEC;
                        OP_LW, OP_SW: state_d = MEM_ADDR;
                        OP_BEQ:       state_d = BRANCH;
                        OP_J:         state_d = JUMP;
                        OP_JAL:       state_d = JAL;
`ifdef MC_CONTROL_ADDI_EN
                        OP_ADDI:      state_d = ADDI_EXEC;
`endif
                        default:      state_d = TRAP;
                    endcase
                end
                MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    state_d = (opcode == OP_SW) ? MEM_WR : MEM_RD;
                end
                MEM_RD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    if (mem_ready) state_d = MEM_WB;
                end
                MEM_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = RD_RT;
                    MemtoReg = MTR_MDR;
                    state_d  = FETCH;
                end
                MEM_WR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    if (mem_ready) state_d = FETCH;
                end
                EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_B;
                    aluop_c = ALUOP_FUNCT;
                    state_d = ALU_WB;
                end
                ALU_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = RD_RD;
                    MemtoReg = MTR_ALUOUT;
                    state_d  = FETCH;
                end
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUSrcB     = SRCB_B;
                    aluop_c     = ALUOP_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = PCS_ALUOUT;
                    state_d     = FETCH;
                end
                JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = PCS_JUMP;
                    state_d  = FETCH;
                end
                // PC already holds PC+4 from FETCH, so it is the link value.
                JAL: begin
                    RegWrite = 1'b1;
                    RegDst   = RD_RA;
                    MemtoReg = MTR_PC;
                    PCWrite  = 1'b1;
                    PCSource = PCS_JUMP;
                    state_d  = FETCH;
                end
`ifdef MC_CONTROL_ADDI_EN
                ADDI_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    aluop_c = ALUOP_ADD;
                    state_d = ADDI_WB;
                end
                ADDI_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = RD_RT;
                    MemtoReg = MTR_ALUOUT;
                    state_d  = FETCH;
                end
`endif
                TRAP: begin
                    illegal = 1'b1;
                end
                default: begin
                    state_d = TRAP;
                end
            endcase
        end
    end

    assign AluOP = ALUOP_W'(aluop_c);

    // Only final states ever move into FETCH, so any such move is a retirement.
    assign retire   = !reset && (state_d == FETCH) && (state_q != FETCH);
    assign count_en = !reset && (state_q != TRAP);

    mc_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk        (clk),
        .reset      (reset),
        .count_en   (count_en),
        .retire     (retire),
        .cycle_count(cycle_count),
        .instr_count(instr_count)
    );

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - self-checking bench for mc_control
module tb_mc_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = 6'd0;
    logic        mem_ready = 1'b0;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite;
    logic [1:0]  MemtoReg, RegDst, ALUSrcB, PCSource, AluOP;
    logic        illegal;
    logic [31:0] cycle_count, instr_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mc_control #(.CNT_W(32), .ALUOP_W(2)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .AluOP(AluOP), .illegal(illegal), .cycle_count(cycle_count), .instr_count(instr_count)
    );

    logic [18:0] dut_vec;
    assign dut_vec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite,
                      MemtoReg, RegDst, ALUSrcB, PCSource, AluOP, illegal};

    localparam int P_FETCH = 0, P_DEC = 1, P_MADDR = 2, P_MRD = 3, P_MWB = 4, P_MWR = 5,
                   P_EXEC = 6, P_AWB = 7, P_BR = 8, P_J = 9, P_JAL = 10, P_IEX = 11, P_IWB = 12,
                   P_TRAP = 13;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected datapath controls for one step of an instruction, straight from the control table.
    function automatic logic [18:0] exp_vec(input int step, input logic rdy);
        logic pcw, pcwc, iord, mr, mw, irw, srca, rw, ill;
        logic [1:0] mtr, rdst, srcb, pcs, aop;
        pcw = 0; pcwc = 0; iord = 0; mr = 0; mw = 0; irw = 0; srca = 0; rw = 0; ill = 0;
        mtr = 0; rdst = 0; srcb = 0; pcs = 0; aop = 0;
        case (step)
            P_FETCH: begin mr = 1; irw = rdy; pcw = rdy; srcb = 2'b01; end
            P_DEC:   srcb = 2'b11;
            P_MADDR: begin srca = 1; srcb = 2'b10; end
            P_MRD:   begin mr = 1; iord = 1; end
            P_MWB:   begin rw = 1; mtr = 2'b01; end
            P_MWR:   begin mw = 1; iord = 1; end
            P_EXEC:  begin srca = 1; aop = 2'b10; end
            P_AWB:   begin rw = 1; rdst = 2'b01; end
            P_BR:    begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            P_J:     begin pcw = 1; pcs = 2'b10; end
            P_JAL:   begin rw = 1; rdst = 2'b10; mtr = 2'b10; pcw = 1; pcs = 2'b10; end
            P_IEX:   begin srca = 1; srcb = 2'b10; end
            P_IWB:   rw = 1;
            P_TRAP:  ill = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, srca, rw, mtr, rdst, srcb, pcs, aop, ill};
    endfunction

    function automatic bit is_mem_step(input int step);
        return step == P_FETCH || step == P_MRD || step == P_MWR;
    endfunction

    task automatic build_steps(input logic [5:0] op, output int steps[$]);
        steps = {};
        steps.push_back(P_FETCH);
        steps.push_back(P_DEC);
        case (op)
            6'b000000: begin steps.push_back(P_EXEC); steps.push_back(P_AWB); end
            6'b100011: begin steps.push_back(P_MADDR); steps.push_back(P_MRD); steps.push_back(P_MWB); end
            6'b101011: begin steps.push_back(P_MADDR); steps.push_back(P_MWR); end
            6'b000100: steps.push_back(P_BR);
            6'b000010: steps.push_back(P_J);
            6'b000011: steps.push_back(P_JAL);
            6'b001000: begin steps.push_back(P_IEX); steps.push_back(P_IWB); end
            default:   steps.push_back(P_TRAP);
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [5:0] op;
        int         lat;
        bit         trap;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int  n;
        bit  done;
        int  steps[$];
        int  cyc_m, ret_m, mw_cnt, wr_cnt, pcwc_cnt, rw_cnt;
        logic [5:0] op;
        logic [5:0] ops[$];
        logic rdy_sched[7];

        tbl[0] = '{6'b000000, 4, 1'b0};
        tbl[1] = '{6'b100011, 5, 1'b0};
        tbl[2] = '{6'b101011, 4, 1'b0};
        tbl[3] = '{6'b000100, 3, 1'b0};
        tbl[4] = '{6'b000010, 3, 1'b0};
        tbl[5] = '{6'b000011, 3, 1'b0};
`ifdef MC_CONTROL_ADDI_EN
        tbl[6] = '{6'b001000, 4, 1'b0};
`else
        tbl[6] = '{6'b001000, 2, 1'b1};
`endif
        tbl[7] = '{6'b111111, 2, 1'b1};
        tbl[8] = '{6'b000001, 2, 1'b1};

        // Reset state: every output low, counters clear.
        mem_ready = 1'b1;
        @(posedge clk); #1;
        check("reset_outputs", dut_vec, 0);
        check("reset_cycle_count", cycle_count, 0);
        check("reset_instr_count", instr_count, 0);

        // Table: one instruction per reset, mem_ready held high.
        for (int i = 0; i < 9; i++) begin
            do_reset();
            opcode = tbl[i].op;
            mem_ready = 1'b1;
            n = 0;
            done = 0;
            while (!done && n < 20) begin
                @(posedge clk); #1;
                n++;
                if (instr_count != 0 || illegal) done = 1;
            end
            check($sformatf("latency_op%02h", tbl[i].op), n, tbl[i].lat);
            check($sformatf("cycles_op%02h", tbl[i].op), cycle_count, tbl[i].lat);
            if (tbl[i].trap) begin
                check("trap_outputs", dut_vec, exp_vec(P_TRAP, 1'b1));
                repeat (3) @(posedge clk);
                #1;
                check("trap_cycle_frozen", cycle_count, 2);
                check("trap_instr_frozen", instr_count, 0);
                check("trap_sticky", illegal, 1);
                do_reset();
                #1;
                check("trap_reset_illegal", illegal, 0);
                check("trap_reset_fetch", dut_vec, exp_vec(P_FETCH, 1'b1));
            end else begin
                check($sformatf("retired_op%02h", tbl[i].op), instr_count, 1);
            end
        end

        // sw stalled 3 cycles in the write state.
        rdy_sched = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        opcode = 6'b101011;
        mw_cnt = 0;
        wr_cnt = 0;
        for (int c = 0; c < 7; c++) begin
            mem_ready = rdy_sched[c];
            #1;
            if (MemWrite) mw_cnt++;
            if (MemWrite && mem_ready) wr_cnt++;
            @(negedge clk);
        end
        #1;
        check("sw_memwrite_cycles", mw_cnt, 4);
        check("sw_single_write", wr_cnt, 1);
        check("sw_instr_count", instr_count, 1);
        check("sw_cycle_count", cycle_count, 7);

        // beq, j, jal back to back.
        do_reset();
        mem_ready = 1'b1;
        pcwc_cnt = 0;
        ops = {6'b000100, 6'b000010, 6'b000011};
        foreach (ops[k]) begin
            opcode = ops[k];
            for (int c = 0; c < 3; c++) begin
                #1;
                if (PCWriteCond) pcwc_cnt++;
                if (k == 2 && c == 2) begin
                    check("jal_regdst", RegDst, 2'b10);
                    check("jal_memtoreg", MemtoReg, 2'b10);
                    check("jal_pcwrite", PCWrite, 1);
                end
                @(negedge clk);
            end
        end
        #1;
        check("bjj_pcwritecond", pcwc_cnt, 1);
        check("bjj_instr_count", instr_count, 3);
        check("bjj_cycle_count", cycle_count, 9);

        // Reset while lw waits in the read state.
        do_reset();
        opcode = 6'b100011;
        rw_cnt = 0;
        mem_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) mem_ready = 1'b0;
            #1;
            if (RegWrite) rw_cnt++;
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        if (RegWrite) rw_cnt++;
        check("midreset_outputs", dut_vec, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        if (RegWrite) rw_cnt++;
        check("midreset_fetch", dut_vec, exp_vec(P_FETCH, 1'b0));
        check("midreset_regwrite", rw_cnt, 0);
        check("midreset_cycle_count", cycle_count, 0);
        check("midreset_instr_count", instr_count, 0);

        // Random instruction stream with random memory stalls against the step model.
        do_reset();
        cyc_m = 0;
        ret_m = 0;
        for (int k = 0; k < 150; k++) begin
`ifdef MC_CONTROL_ADDI_EN
            case ($urandom_range(0, 6))
`else
            case ($urandom_range(0, 5))
`endif
                0: op = 6'b000000;
                1: op = 6'b100011;
                2: op = 6'b101011;
                3: op = 6'b000100;
                4: op = 6'b000010;
                5: op = 6'b000011;
                default: op = 6'b001000;
            endcase
            build_steps(op, steps);
            opcode = op;
            foreach (steps[s]) begin
                done = 0;
                n = 0;
                while (!done) begin
                    mem_ready = ($urandom_range(0, 3) != 0);
                    #1;
                    if (s == 0 && n == 0) begin
                        check("rand_cycle_count", cycle_count, cyc_m);
                        check("rand_instr_count", instr_count, ret_m);
                    end
                    check($sformatf("rand_op%02h_step%0d", op, s), dut_vec, exp_vec(steps[s], mem_ready));
                    done = !is_mem_step(steps[s]) || mem_ready;
                    cyc_m++;
                    n++;
                    @(negedge clk);
                    if (!done && n > 50) begin
                        check("rand_stall_bound", n, 0);
                        done = 1;
                    end
                end
            end
            ret_m++;
        end
        mem_ready = 1'b0;
        #1;
        check("rand_final_cycle_count", cycle_count, cyc_m);
        check("rand_final_instr_count", instr_count, ret_m);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
